// File: rtl/data_obi_initiator.sv
// data_obi_initiator: drives the 33-bit CHERIoT data OBI bus from a simple
// valid/ready command queue. Granted requests wait in an in-order pending
// FIFO until their response arrives. The response then returns with the
// command tag.
// Optional: define DATA_OBI_INIT_TIMEOUT_EN to build the response watchdog
// and the timeout_err port.
module data_obi_initiator #(
  parameter int MAX_OUTST   = 4,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_we,
  input  logic [3:0]                 cmd_be,
  input  logic                       cmd_is_cap,
  input  logic [31:0]                cmd_addr,
  input  logic [32:0]                cmd_wdata,
  input  logic [TAG_W-1:0]           cmd_tag,
  output logic                       data_req,
  output logic                       data_we,
  output logic [3:0]                 data_be,
  output logic                       data_is_cap,
  output logic [31:0]                data_addr,
  output logic [32:0]                data_wdata,
  input  logic                       data_gnt,
  input  logic                       data_rvalid,
  input  logic [32:0]                data_rdata,
  input  logic                       data_err,
  output logic                       rsp_valid,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       rsp_we,
  output logic [32:0]                rsp_rdata,
  output logic                       rsp_err,
  output logic [$clog2(MAX_OUTST):0] outst_cnt,
  output logic                       proto_err
`ifdef DATA_OBI_INIT_TIMEOUT_EN
  ,
  output logic                       timeout_err
`endif
);

  localparam int CNT_W = $clog2(MAX_OUTST) + 1;
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  // Reject unsupported configurations at elaboration time.
  if (MAX_OUTST < 1 || MAX_OUTST > 16 || (MAX_OUTST & (MAX_OUTST - 1)) != 0)
    $error("MAX_OUTST must be a power of 2 in 1..16");
  if (TIMEOUT_CYC < 1)
    $error("TIMEOUT_CYC must be positive");

  logic                req_q, we_q, cap_q;
  logic [3:0]          be_q;
  logic [31:0]         addr_q;
  logic [32:0]         wdata_q;
  logic [TAG_W-1:0]    tag_q;
  logic [TAG_W:0]      fifo_q [MAX_OUTST];
  logic [PTR_W-1:0]    rptr_q, wptr_q;
  logic [CNT_W-1:0]    fcnt_q, outst_q;
  logic                rsp_valid_q, rsp_we_q, rsp_err_q, proto_q;
  logic [TAG_W-1:0]    rsp_tag_q;
  logic [32:0]         rsp_rdata_q;
  logic                accept, push, pop;
  logic [TAG_W:0]      head;

  function automatic logic [PTR_W-1:0] ptr_nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  // A same-cycle push into an empty FIFO cannot be popped, so pop looks only
  // at entries granted in earlier cycles.
  assign pop       = data_rvalid & (fcnt_q != '0);
  assign push      = req_q & data_gnt;
  assign cmd_ready = (!req_q | data_gnt) & ((outst_q < CNT_W'(MAX_OUTST)) | pop);
  assign accept    = cmd_valid & cmd_ready;
  assign head      = fifo_q[rptr_q];

  // Request register: load on accept, hold until granted, drop if not reloaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q <= 1'b0; we_q <= 1'b0; cap_q <= 1'b0; be_q <= '0;
      addr_q <= '0; wdata_q <= '0; tag_q <= '0;
    end else if (accept) begin
      req_q <= 1'b1; we_q <= cmd_we; cap_q <= cmd_is_cap; be_q <= cmd_be;
      addr_q <= cmd_addr; wdata_q <= cmd_wdata; tag_q <= cmd_tag;
    end else if (data_gnt) begin
      req_q <= 1'b0;
    end
  end

  // Pending FIFO storage: {tag, we} of each granted request.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= {tag_q, we_q};
  end

  // Pending FIFO pointers, occupancy and in-flight counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr_q <= '0; wptr_q <= '0; fcnt_q <= '0; outst_q <= '0;
    end else begin
      if (push) wptr_q <= ptr_nxt(wptr_q);
      if (pop)  rptr_q <= ptr_nxt(rptr_q);
      fcnt_q  <= fcnt_q + CNT_W'(push) - CNT_W'(pop);
      outst_q <= outst_q + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  // Response register: one-cycle pulse carrying the popped head entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0; rsp_tag_q <= '0; rsp_we_q <= 1'b0;
      rsp_rdata_q <= '0; rsp_err_q <= 1'b0;
    end else begin
      rsp_valid_q <= pop;
      if (pop) begin
        rsp_tag_q   <= head[TAG_W:1];
        rsp_we_q    <= head[0];
        rsp_rdata_q <= head[0] ? '0 : data_rdata;
        rsp_err_q   <= data_err;
      end
    end
  end

  // Sticky responder protocol violation flag.
  always_ff @(posedge clk) begin
    if (!rst_n) proto_q <= 1'b0;
    else if ((data_rvalid & (fcnt_q == '0)) | (data_gnt & !req_q)) proto_q <= 1'b1;
  end

`ifdef DATA_OBI_INIT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q;

  // Watchdog next value: idle-with-work cycles, saturating at the limit.
  always_comb begin
    wd_d = wd_q;
    if (outst_q == '0 || data_gnt || data_rvalid) wd_d = '0;
    else if (wd_q != WD_W'(TIMEOUT_CYC))          wd_d = wd_q + 1'b1;
  end

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q <= '0; to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      if (wd_d == WD_W'(TIMEOUT_CYC) && !to_q) begin
        to_q <= 1'b1;
        $error("data_obi_initiator: response timeout");
      end
    end
  end

  assign timeout_err = to_q;
`endif

  assign data_req    = req_q;
  assign data_we     = we_q;
  assign data_be     = be_q;
  assign data_is_cap = cap_q;
  assign data_addr   = addr_q;
  assign data_wdata  = wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_we      = rsp_we_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign outst_cnt   = outst_q;
  assign proto_err   = proto_q;

endmodule

// File: tb/tb_data_obi_initiator.sv
// tb_data_obi_initiator: directed scenarios plus randomized traffic checked
// against a queue-based transaction model of the initiator.
module tb_data_obi_initiator;
  localparam int MAX = 4;
  localparam int TW  = 4;

  typedef struct packed {
    logic v, we; logic [3:0] be; logic cap; logic [31:0] addr;
    logic [32:0] wdata; logic [TW-1:0] tag;
  } cmd_t;
  typedef struct packed {
    logic [TW-1:0] tag; logic we; logic [32:0] rdata; logic err;
  } rsp_t;

  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_we = 0, cmd_is_cap = 0;
  logic [3:0] cmd_be = 0; logic [31:0] cmd_addr = 0;
  logic [32:0] cmd_wdata = 0; logic [TW-1:0] cmd_tag = 0;
  logic data_gnt = 0, data_rvalid = 0, data_err = 0; logic [32:0] data_rdata = 0;
  logic cmd_ready, data_req, data_we, data_is_cap, rsp_valid, rsp_we, rsp_err, proto_err;
  logic [3:0] data_be; logic [31:0] data_addr; logic [32:0] data_wdata, rsp_rdata;
  logic [TW-1:0] rsp_tag; logic [$clog2(MAX):0] outst_cnt;
`ifdef DATA_OBI_INIT_TIMEOUT_EN
  logic timeout_err;
`endif

  data_obi_initiator #(.MAX_OUTST(MAX), .TAG_W(TW), .TIMEOUT_CYC(256)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_be(cmd_be), .cmd_is_cap(cmd_is_cap), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_tag(cmd_tag), .data_req(data_req), .data_we(data_we),
    .data_be(data_be), .data_is_cap(data_is_cap), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata), .data_err(data_err), .rsp_valid(rsp_valid),
    .rsp_tag(rsp_tag), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .outst_cnt(outst_cnt), .proto_err(proto_err)
`ifdef DATA_OBI_INIT_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  cmd_t iss_q[$];   // accepted, not yet granted
  rsp_t pend_q[$];  // granted, awaiting response (rdata/err unused here)
  int   inflight = 0;
  bit   exp_rv = 0, exp_proto = 0;
  rsp_t exp_rsp;
  cmd_t idle = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check registered outputs, drive inputs, check cmd_ready,
  // advance the transaction model, then step to just after the next edge.
  task automatic cycle(input cmd_t c, input bit g, input bit rv,
                       input logic [32:0] rd, input bit e);
    bit m_req, exp_ready, acc, push, pop;
    rsp_t ent;
    m_req = (iss_q.size() != 0);
    chk("data_req", 64'(data_req), 64'(m_req));
    if (m_req) begin
      chk("data_we", 64'(data_we), 64'(iss_q[0].we));
      chk("data_be", 64'(data_be), 64'(iss_q[0].be));
      chk("data_cap", 64'(data_is_cap), 64'(iss_q[0].cap));
      chk("data_addr", 64'(data_addr), 64'(iss_q[0].addr));
      chk("data_wdata", 64'(data_wdata), 64'(iss_q[0].wdata));
    end
    chk("outst_cnt", 64'(outst_cnt), 64'(inflight));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (exp_rv) begin
      chk("rsp_tag", 64'(rsp_tag), 64'(exp_rsp.tag));
      chk("rsp_we", 64'(rsp_we), 64'(exp_rsp.we));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rsp.rdata));
      chk("rsp_err", 64'(rsp_err), 64'(exp_rsp.err));
    end
    chk("proto_err", 64'(proto_err), 64'(exp_proto));

    cmd_valid = c.v; cmd_we = c.we; cmd_be = c.be; cmd_is_cap = c.cap;
    cmd_addr = c.addr; cmd_wdata = c.wdata; cmd_tag = c.tag;
    data_gnt = g; data_rvalid = rv; data_rdata = rd; data_err = e;
    #1;
    pop  = rv && (pend_q.size() != 0);
    push = m_req && g;
    exp_ready = (!m_req || g) && (inflight < MAX || pop);
    chk("cmd_ready", 64'(cmd_ready), 64'(exp_ready));
    acc = c.v && exp_ready;
    if ((rv && pend_q.size() == 0) || (g && !m_req)) exp_proto = 1;
    exp_rv = pop;
    if (pop) begin
      ent = pend_q.pop_front();
      exp_rsp = '{tag: ent.tag, we: ent.we, rdata: ent.we ? 33'd0 : rd, err: e};
      inflight--;
    end
    if (push) begin
      ent = '0; ent.tag = iss_q[0].tag; ent.we = iss_q[0].we;
      pend_q.push_back(ent);
      void'(iss_q.pop_front());
    end
    if (acc) begin iss_q.push_back(c); inflight++; end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    cmd_valid = 0; data_gnt = 0; data_rvalid = 0; data_err = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 64'(data_req), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_proto", 64'(proto_err), 0);
    chk("rst_outst", 64'(outst_cnt), 0);
    chk("rst_addr", 64'(data_addr), 0);
    chk("rst_rdata", 64'(rsp_rdata), 0);
    iss_q.delete(); pend_q.delete();
    inflight = 0; exp_rv = 0; exp_proto = 0;
    rst_n = 1;
  endtask

  function automatic cmd_t mk(input bit we, input logic [31:0] addr,
                              input logic [3:0] be, input logic [TW-1:0] tag);
    cmd_t c;
    c = '0; c.v = 1; c.we = we; c.addr = addr; c.be = be; c.tag = tag;
    c.wdata = {1'b1, 32'hC0DE_0000 | 32'(tag)};
    return c;
  endfunction

  initial begin
    cmd_t c;
    bit g, rv;
    do_reset();

    // Single read, granted after two stalled cycles.
    cycle(mk(0, 32'h8000_0010, 4'hF, 3), 0, 0, 0, 0);
    cycle(idle, 0, 0, 0, 0);
    cycle(idle, 0, 0, 0, 0);
    chk("rd_req_held", 64'(data_req), 1);
    chk("rd_addr_held", 64'(data_addr), 64'h8000_0010);
    cycle(idle, 1, 0, 0, 0);
    cycle(idle, 0, 1, 33'h1_DEAD_BEEF, 0);
    chk("rd_rsp_valid", 64'(rsp_valid), 1);
    chk("rd_rsp_tag", 64'(rsp_tag), 3);
    chk("rd_rsp_rdata", 64'(rsp_rdata), 64'h1_DEAD_BEEF);
    cycle(idle, 0, 0, 0, 0);

    // Back-to-back writes, then a full-plus-simultaneous accept.
    cycle(mk(1, 32'h100, 4'h3, 0), 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) cycle(mk(1, 32'h100 + 32'(4*i), 4'hF, TW'(i)), 1, 0, 0, 0);
    cycle(mk(0, 32'h200, 4'hF, 9), 1, 0, 0, 0);
    chk("b2b_full", 64'(outst_cnt), 4);
    chk("b2b_ready_lo", 64'(cmd_ready), 0);
    repeat (4) cycle(mk(0, 32'h200, 4'hF, 9), 0, 0, 0, 0);
    cycle(mk(0, 32'h200, 4'hF, 9), 0, 1, 33'h1_2345_6789, 0);
    chk("full_sim_cnt", 64'(outst_cnt), 4);
    chk("full_sim_tag", 64'(rsp_tag), 0);
    chk("full_sim_rdata", 64'(rsp_rdata), 0);
    cycle(idle, 1, 1, 33'h5, 0);
    for (int i = 0; i < 3; i++) cycle(idle, 0, 1, 33'h0_0000_0077, 0);
    cycle(idle, 0, 0, 0, 0);
    chk("b2b_drain", 64'(outst_cnt), 0);

    // Error response.
    cycle(mk(0, 32'h0000_1000, 4'hF, 7), 0, 0, 0, 0);
    cycle(idle, 1, 0, 0, 0);
    cycle(idle, 0, 1, 33'h0_1111_2222, 1);
    chk("err_rsp_err", 64'(rsp_err), 1);
    chk("err_outst", 64'(outst_cnt), 0);
    chk("err_proto", 64'(proto_err), 0);
    cycle(idle, 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      c = '0;
      c.v = ($urandom_range(0, 9) < 7); c.we = 1'($urandom); c.be = 4'($urandom);
      c.cap = 1'($urandom); c.addr = $urandom; c.wdata = {1'($urandom), 32'($urandom)};
      c.tag = TW'($urandom);
      g  = (iss_q.size() != 0) && ($urandom_range(0, 2) != 0);
      rv = (pend_q.size() != 0) && ($urandom_range(0, 9) < 4);
      cycle(c, g, rv, {1'($urandom), 32'($urandom)}, 1'($urandom));
    end

    // Reset mid-operation, then a stale response is a protocol error.
    do_reset();
    cycle(idle, 0, 1, 33'h3, 0);
    chk("stale_no_rsp", 64'(rsp_valid), 0);
    repeat (3) cycle(idle, 0, 0, 0, 0);
    chk("proto_sticky", 64'(proto_err), 1);
    do_reset();
    cycle(idle, 1, 0, 0, 0);
    chk("gnt_idle_proto", 64'(proto_err), 1);
    cycle(idle, 0, 0, 0, 0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
